// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 conditions operand B for subtract and forms 4-bit group
// propagate/generate terms. Stage 2 resolves the group carries through the
// lookahead unit, expands them to bit carries, and registers the result.
// Valid/ready handshake on both sides with full-rate throughput.
module cla_pipe_addsub #(
   parameter  int WIDTH = 16,
   localparam int NGRP  = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             P,
   output logic             G
);

   // Stage-1 combinational terms
   logic [WIDTH-1:0] b_in, p_in, g_in;
   logic             c0_in;
   logic [NGRP-1:0]  pg_in, gg_in;

   // Stage-1 registers
   logic [WIDTH-1:0] s1_a, s1_b;
   logic             s1_c0;
   logic [NGRP-1:0]  s1_pg, s1_gg;
   logic             s1_valid;

   // Stage-2 combinational terms
   logic [NGRP:0]    grp_c;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] p2, sum_nxt;
   logic [2:0]       gp, gg;
   logic             blk_p, blk_g, cout_nxt, ovf_nxt;

   // Handshake
   logic s2_valid, s1_load, s2_load;

   // Subtract is a + ~b + ~cin; form bit and 4-bit group propagate/generate.
   always_comb begin
      // NOTE: every variable gets a value before any branch or loop so no path leaves it unassigned and no latch is inferred.
      b_in  = sub ? ~in2 : in2;
      c0_in = sub ? ~cin : cin;
      p_in  = in1 ^ b_in;
      g_in  = in1 & b_in;
      pg_in = '0;
      gg_in = '0;
      for (int k = 0; k < NGRP; k++) begin
         pg_in[k] = &p_in[4*k +: 4];
         gg_in[k] = g_in[4*k+3]
                  | (p_in[4*k+3] & g_in[4*k+2])
                  | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                  | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
      end
   end

   // Advance rules: S2 drains when its slot frees, S1 accepts when its slot frees.
   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign in_ready  = ~s1_valid | s2_load;
   assign s1_load   = in_valid & in_ready;
   assign out_valid = s2_valid;

   // Stage-1 register: conditioned operands, carry-in and group P/G.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (!rst) begin
         // NOTE: datapath registers are plain enabled flops, not memory arrays, so resetting them is cheap and keeps held outputs deterministic.
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_c0    <= 1'b0;
         s1_pg    <= '0;
         s1_gg    <= '0;
      end else begin
         s1_valid <= s1_load | (s1_valid & ~s2_load);
         if (s1_load) begin
            s1_a  <= in1;
            s1_b  <= b_in;
            s1_c0 <= c0_in;
            s1_pg <= pg_in;
            s1_gg <= gg_in;
         end
      end
   end

   // Lookahead carry unit across groups, then in-group lookahead bit carries.
   always_comb begin
      p2      = s1_a ^ s1_b;
      grp_c   = '0;
      c       = '0;
      gp      = '0;
      gg      = '0;
      blk_g   = 1'b0;
      grp_c[0] = s1_c0;
      for (int k = 0; k < NGRP; k++) begin
         grp_c[k+1] = s1_gg[k] | (s1_pg[k] & grp_c[k]);
      end
      for (int k = 0; k < NGRP; k++) begin
         gp         = p2[4*k +: 3];
         gg         = s1_a[4*k +: 3] & s1_b[4*k +: 3];
         c[4*k]     = grp_c[k];
         c[4*k+1]   = gg[0] | (gp[0] & grp_c[k]);
         c[4*k+2]   = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & grp_c[k]);
         c[4*k+3]   = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                    | (gp[2] & gp[1] & gp[0] & grp_c[k]);
      end
      c[WIDTH] = grp_c[NGRP];
      for (int k = 0; k < NGRP; k++) begin
         blk_g = s1_gg[k] | (s1_pg[k] & blk_g);
      end
      blk_p    = &s1_pg;
      sum_nxt  = p2 ^ c[WIDTH-1:0];
      cout_nxt = blk_g | (blk_p & s1_c0);
      ovf_nxt  = c[WIDTH] ^ c[WIDTH-1];
   end

   // Stage-2 register: result and flags, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
         P        <= 1'b0;
         G        <= 1'b0;
      end else begin
         s2_valid <= s2_load | (s2_valid & ~out_ready);
         if (s2_load) begin
            sum  <= sum_nxt;
            cout <= cout_nxt;
            ovf  <= ovf_nxt;
            P    <= blk_p;
            G    <= blk_g;
         end
      end
   end

endmodule
